// File: rtl/pdr_sort_pkg.sv
// Shared types for the par_sort frame sequencer: FSM states, index type and
// the parameter legality check used at elaboration.
package pdr_sort_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SWEEP,
      DRAIN,
      OUT
   } sort_state_e;

   typedef logic [7:0] idx_t;

   localparam idx_t IDX_INVALID = 8'hFF;

   // The index counter is 8 bits, so COL-1 must stay below 256.
   function automatic bit sort_cfg_ok(input int col, input int topk);
      return ((col == 16) || (col == 64)) && (topk >= 1) && (topk <= col) && ((col - 1) <= 255);
   endfunction

endpackage

// File: rtl/par_sort_ctrl_if.sv
// Frame, comparator and result buses of the par_sort sequencer. The master
// modport is the sequencer's view; slave is the surrounding environment.
interface par_sort_ctrl_if #(
   parameter int IW   = 32,
   parameter int COL  = 64,
   parameter int TOPK = 16
);

   logic [COL-1:0][IW-1:0]  i_data;
   logic                    i_valid;
   logic                    o_ready;
   logic [COL-1:0][IW-1:0]  o_cmp_data;
   logic [7:0]              o_cmp_index;
   logic                    o_cmp_valid;
   logic [7:0]              i_cmp_score;
   logic                    i_cmp_valid;
   logic [TOPK-1:0][7:0]    o_rank_idx;
   logic [TOPK-1:0][IW-1:0] o_rank_data;
   logic                    o_valid;
   logic                    i_ready;
   logic                    o_busy;
   logic                    o_err;

   modport master (
      input  i_data, i_valid, i_cmp_score, i_cmp_valid, i_ready,
      output o_ready, o_cmp_data, o_cmp_index, o_cmp_valid,
             o_rank_idx, o_rank_data, o_valid, o_busy, o_err
   );

   modport slave (
      output i_data, i_valid, i_cmp_score, i_cmp_valid, i_ready,
      input  o_ready, o_cmp_data, o_cmp_index, o_cmp_valid,
             o_rank_idx, o_rank_data, o_valid, o_busy, o_err
   );

endinterface

// File: rtl/par_sort_rank_tbl.sv
// TOPK-entry rank table plus the per-frame score hit mask. The first write to
// a score wins; repeats and out-of-range scores raise dup_err.
module par_sort_rank_tbl
   import pdr_sort_pkg::*;
#(
   parameter int IW   = 32,
   parameter int COL  = 64,
   parameter int TOPK = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    clear,
   input  logic                    we,
   input  idx_t                    rank,
   input  idx_t                    col,
   input  logic [IW-1:0]           data,
   output logic                    dup_err,
   output logic [TOPK-1:0][7:0]    rank_idx,
   output logic [TOPK-1:0][IW-1:0] rank_data
);

   logic [COL-1:0] hit;
   logic           in_range;
   logic           hit_prev;

   always_comb begin
      in_range = (rank < idx_t'(COL));
      hit_prev = 1'b0;
      for (int c = 0; c < COL; c++) begin
         if (rank == idx_t'(c)) hit_prev = hit[c];
      end
   end

   assign dup_err = we && (!in_range || hit_prev);

   // Ranks never written this frame read back as IDX_INVALID with zero data.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n || clear) begin
         hit       <= '0;
         rank_idx  <= {TOPK{IDX_INVALID}};
         rank_data <= '0;
      end else if (we && in_range && !hit_prev) begin
         for (int c = 0; c < COL; c++) begin
            if (rank == idx_t'(c)) hit[c] <= 1'b1;
         end
         for (int r = 0; r < TOPK; r++) begin
            if (rank == idx_t'(r)) begin
               rank_idx[r]  <= col;
               rank_data[r] <= data;
            end
         end
      end
   end

endmodule

// File: rtl/par_sort_ctrl.sv
// Frame sequencer for the par_compare rank engine: latches a frame, sweeps the
// compare index, collects scores into the rank table and presents the result.
module par_sort_ctrl
   import pdr_sort_pkg::*;
#(
   parameter int IW   = 32,
   parameter int COL  = 64,
   parameter int TOPK = 16,
   parameter int TMO  = 15
) (
   input logic             i_clk,
   input logic             i_reset_n,
   par_sort_ctrl_if.master bus
);

   localparam int   CW       = $clog2(COL);
   localparam int   TW       = (TMO > 1) ? $clog2(TMO) : 1;
   localparam idx_t LAST_IDX = idx_t'(COL - 1);
   localparam idx_t COL_CNT  = idx_t'(COL);

   if (!sort_cfg_ok(COL, TOPK)) begin : g_cfg_check
      $error("par_sort_ctrl: illegal COL/TOPK combination");
   end

   sort_state_e            state;
   sort_state_e            state_nx;
   logic [COL-1:0][IW-1:0] data_q;
   idx_t                   issue_cnt;
   idx_t                   ret_cnt;
   logic [TW-1:0]          tmo_cnt;
   logic                   err_q;
   logic                   accept;
   logic                   tmo_hit;
   logic                   capture;
   logic                   tbl_we;
   logic                   tbl_err;
   logic [IW-1:0]          col_data;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_nx;
   end

   // DRAIN leaves early once every column has reported, otherwise after TMO cycles.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      tmo_hit  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_valid) begin
               accept   = 1'b1;
               state_nx = LOAD;
            end
         end
         LOAD:  state_nx = SWEEP;
         SWEEP: if (issue_cnt == LAST_IDX) state_nx = DRAIN;
         DRAIN: begin
            if (ret_cnt == COL_CNT) begin
               state_nx = OUT;
            end else if (tmo_cnt == TW'(TMO - 1)) begin
               tmo_hit  = 1'b1;
               state_nx = OUT;
            end
         end
         OUT:     if (bus.i_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign capture  = ((state == SWEEP) || (state == DRAIN)) && bus.i_cmp_valid;
   assign tbl_we   = capture && (ret_cnt != COL_CNT);
   assign col_data = data_q[ret_cnt[CW-1:0]];

   // Returns arrive in issue order, so the return counter names the column scored.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         data_q    <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
         tmo_cnt   <= '0;
         err_q     <= 1'b0;
      end else if (accept) begin
         data_q    <= bus.i_data;
         issue_cnt <= '0;
         ret_cnt   <= '0;
         tmo_cnt   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (state == SWEEP) issue_cnt <= (issue_cnt == LAST_IDX) ? '0 : issue_cnt + 8'd1;
         if (tbl_we)         ret_cnt   <= ret_cnt + 8'd1;
         if (state == DRAIN) tmo_cnt   <= tmo_cnt + TW'(1);
         if (tbl_err || (capture && !tbl_we) || tmo_hit) err_q <= 1'b1;
      end
   end

   par_sort_rank_tbl #(
      .IW   (IW),
      .COL  (COL),
      .TOPK (TOPK)
   ) u_rank_tbl (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .clear     (accept),
      .we        (tbl_we),
      .rank      (bus.i_cmp_score),
      .col       (ret_cnt),
      .data      (col_data),
      .dup_err   (tbl_err),
      .rank_idx  (bus.o_rank_idx),
      .rank_data (bus.o_rank_data)
   );

   assign bus.o_ready     = (state == IDLE);
   assign bus.o_busy      = (state != IDLE);
   assign bus.o_valid     = (state == OUT);
   assign bus.o_cmp_valid = (state == SWEEP);
   assign bus.o_cmp_index = issue_cnt;
   assign bus.o_cmp_data  = data_q;
   assign bus.o_err       = err_q;

endmodule
